// File: rtl/sensor_display_mux.sv
// ============================================================================
// sensor_display_mux : byte-to-BCD conversion and 8-digit 7-segment scan driver
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int STALE_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temp,
  input  logic [7:0] hum,
  input  logic       data_valid,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       busy
);

  localparam int         RW      = $clog2(REFRESH_DIV);
  localparam int         SW      = $clog2(STALE_CYCLES + 1);
  localparam logic [6:0] C_BLANK = 7'b1111111;
  localparam logic [6:0] C_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [19:0]     tsh_q, tsh_d, hsh_q, hsh_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [7:0]      pt_q, pt_d, ph_q, ph_d;
  logic [11:0]     tbcd_q, tbcd_d, hbcd_q, hbcd_d;
  logic            has_data_q, has_data_d;
  logic [SW-1:0]   stale_q, stale_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      an_q, an_d;
  logic            start;
  logic [11:0]     bcd_sel;

  // Shift register layout: {hundreds, tens, units, binary byte}
  function automatic logic [19:0] dd_step(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    if (y[11:8]  >= 4'd5) y[11:8]  = y[11:8]  + 4'd3;
    if (y[15:12] >= 4'd5) y[15:12] = y[15:12] + 4'd3;
    if (y[19:16] >= 4'd5) y[19:16] = y[19:16] + 4'd3;
    return {y[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = C_BLANK;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    tsh_d      = tsh_q;
    hsh_d      = hsh_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    pt_d       = pt_q;
    ph_d       = ph_q;
    tbcd_d     = tbcd_q;
    hbcd_d     = hbcd_q;
    has_data_d = has_data_q;
    stale_d    = stale_q;
    start      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_valid || pending_q) begin
          // A fresh strobe supersedes whatever is parked in the pending buffer
          start     = 1'b1;
          tsh_d     = {12'd0, (data_valid ? temp : pt_q)};
          hsh_d     = {12'd0, (data_valid ? hum  : ph_q)};
          pending_d = 1'b0;
          cnt_d     = 3'd0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        tsh_d = dd_step(tsh_q);
        hsh_d = dd_step(hsh_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_LOAD;
      end
      S_LOAD: begin
        tbcd_d     = tsh_q[19:8];
        hbcd_d     = hsh_q[19:8];
        has_data_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (data_valid && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
      pt_d      = temp;
      ph_d      = hum;
    end

    if (state_q == S_LOAD) begin
      stale_d = '0;
    end else if (has_data_q && !start) begin
      if (stale_q == SW'(STALE_CYCLES - 1)) begin
        has_data_d = 1'b0;
        stale_d    = '0;
      end else begin
        stale_d = stale_q + SW'(1);
      end
    end
  end

  always_comb begin
    ref_d   = ref_q + RW'(1);
    idx_d   = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 3'd1;
    end
    an_d    = ~(8'b1 << idx_q);
    bcd_sel = idx_q[2] ? tbcd_q : hbcd_q;
    // Position within a group: 0 units, 1 tens, 2 hundreds, 3 spacer
    case (idx_q[1:0])
      2'd0:    seg_d = enc(bcd_sel[3:0]);
      2'd1:    seg_d = ((bcd_sel[11:8] == 4'd0) && (bcd_sel[7:4] == 4'd0)) ? C_BLANK : enc(bcd_sel[7:4]);
      2'd2:    seg_d = (bcd_sel[11:8] == 4'd0) ? C_BLANK : enc(bcd_sel[11:8]);
      default: seg_d = C_BLANK;
    endcase
    if (!has_data_q) seg_d = (idx_q[1:0] == 2'd3) ? C_BLANK : C_DASH;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tsh_q      <= '0;
      hsh_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      pt_q       <= '0;
      ph_q       <= '0;
      tbcd_q     <= '0;
      hbcd_q     <= '0;
      has_data_q <= 1'b0;
      stale_q    <= '0;
      ref_q      <= '0;
      idx_q      <= '0;
      seg_q      <= C_BLANK;
      an_q       <= 8'hFF;
    end else begin
      state_q    <= state_d;
      tsh_q      <= tsh_d;
      hsh_q      <= hsh_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      pt_q       <= pt_d;
      ph_q       <= ph_d;
      tbcd_q     <= tbcd_d;
      hbcd_q     <= hbcd_d;
      has_data_q <= has_data_d;
      stale_q    <= stale_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sensor_display_mux.sv
// ============================================================================
// tb_sensor_display_mux : scoreboard bench, expected display frames queued at stimulus
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_display_mux;

  localparam int         RD   = 4;
  localparam int         SC   = 200;
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] temp = 8'd0;
  logic [7:0] hum = 8'd0;
  logic       data_valid = 1'b0;
  logic [6:0] seg;
  logic [7:0] an;
  logic       busy;

  int          checks = 0;
  int          failures = 0;
  int          busy_cnt = 0;
  logic [55:0] expq[$];   // frames packed {idx7 .. idx0}

  sensor_display_mux #(.REFRESH_DIV(RD), .STALE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .temp(temp), .hum(hum), .data_valid(data_valid),
    .seg(seg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy) busy_cnt++;

  function automatic int an_idx(input logic [7:0] a);
    an_idx = -1;
    for (int i = 0; i < 8; i++) if (a == ~(8'b1 << i)) an_idx = i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse(input logic [7:0] t, input logic [7:0] h);
    @(negedge clk);
    temp = t; hum = h; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic busy_len(input string name, input int exp);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, 64'(n), 64'(exp));
  endtask

  task automatic scan_dash(input string name);
    int i;
    for (int k = 0; k < 8 * RD; k++) begin
      @(negedge clk);
      i = an_idx(an);
      chk({name, "_an"}, 64'(i >= 0), 64'd1);
      chk({name, "_seg"}, 64'(seg), 64'((i == 3 || i == 7) ? BL : DASH));
    end
  endtask

  // Monitor: each completed conversion releases one expected frame, checked slot by slot
  initial begin : monitor
    logic        prev_busy;
    logic        have;
    logic [55:0] cur;
    logic [7:0]  seen;
    int          i;
    prev_busy = 1'b0; have = 1'b0; cur = '0; seen = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        have = 1'b0;
      end else if (prev_busy && !busy) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame_unexpected: conversion completed with no expected frame at %0t", $time);
        end else begin
          cur = expq.pop_front(); have = 1'b1; seen = '0;
        end
      end else if (have) begin
        i = an_idx(an);
        if (i < 0) begin
          checks++; failures++;
          $display("FAIL frame_an: got %0h expected one-hot-low", an);
        end else begin
          chk($sformatf("frame_idx%0d", i), 64'(seg), 64'(cur[i*7 +: 7]));
          seen[i] = 1'b1;
          if (seen == 8'hFF) have = 1'b0;
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int b0;
    int bad;
    int i;
    repeat (5) @(negedge clk);
    chk("reset_seg", 64'(seg), 64'h7F);
    chk("reset_an", 64'(an), 64'hFF);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_digit_an", 64'(an), 64'hFE);
    chk("first_digit_seg", 64'(seg), 64'(DASH));
    scan_dash("reset_scan");
    chk("idle_busy", 64'(busy), 64'd0);

    // temp=25 hum=60
    expq.push_back({BL, BL, S2, S5, BL, BL, S6, S0});
    pulse(8'd25, 8'd60);
    busy_len("busy_len_25_60", 9);
    repeat (40) @(negedge clk);

    // temp=255 hum=0
    expq.push_back({BL, S2, S5, S5, BL, BL, BL, S0});
    pulse(8'd255, 8'd0);
    busy_len("busy_len_255_0", 9);
    repeat (40) @(negedge clk);

    // temp=100 hum=9: internal zero stays lit
    expq.push_back({BL, S1, S0, S0, BL, BL, BL, S9});
    pulse(8'd100, 8'd9);
    busy_len("busy_len_100_9", 9);
    repeat (40) @(negedge clk);

    // Overlap: (30,40) is overwritten by (50,60) in the pending buffer
    expq.push_back({BL, BL, S1, S0, BL, BL, S2, S0});
    expq.push_back({BL, BL, S5, S0, BL, BL, S6, S0});
    b0 = busy_cnt;
    pulse(8'd10, 8'd20);
    @(negedge clk);
    pulse(8'd30, 8'd40);
    pulse(8'd50, 8'd60);
    repeat (25) @(negedge clk);
    chk("overlap_busy_total", 64'(busy_cnt - b0), 64'd18);
    chk("overlap_queue_drained", 64'(expq.size()), 64'd0);
    repeat (40) @(negedge clk);

    // Stale: digits hold for 200 cycles after LOAD, dashes from the following slot update
    expq.push_back({BL, BL, BL, S7, BL, BL, S4, S2});
    pulse(8'd7, 8'd42);
    busy_len("busy_len_stale", 9);
    bad = 0;
    for (int k = 1; k <= SC; k++) begin
      @(negedge clk);
      if (seg == DASH) bad++;
    end
    chk("stale_hold", 64'(bad), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i = an_idx(an);
      chk("stale_dash", 64'(seg), 64'((i == 3 || i == 7) ? BL : DASH));
    end
    expq.push_back({BL, BL, S9, S9, BL, BL, BL, S1});
    pulse(8'd99, 8'd1);
    busy_len("busy_len_restore", 9);
    repeat (40) @(negedge clk);

    // Reset during CONV cycle 4 aborts the conversion
    pulse(8'd88, 8'd77);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_an", 64'(an), 64'hFF);
    chk("abort_seg", 64'(seg), 64'h7F);
    rst = 1'b1;
    scan_dash("abort_scan");
    chk("abort_busy_after", 64'(busy), 64'd0);
    chk("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
